// File: rtl/mux_scan_n1_pkg.sv
// rtl/mux_scan_n1_pkg.sv - shared mode constants, FSM states and helpers for mux_scan_n1
package mux_scan_n1_pkg;

    localparam logic MODE_DIR  = 1'b0;
    localparam logic MODE_SCAN = 1'b1;

    typedef enum logic {
        ST_DIR  = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_n1_rr_pick.sv
// rtl/mux_scan_n1_rr_pick.sv - round-robin picker: first set MASK bit at or after PE, wrapping
module mux_scan_n1_rr_pick #(
    parameter int N = 8,
    parameter int S = 3
) (
    input  logic [N-1:0] mask_i,
    input  logic [S-1:0] pe_i,
    output logic [S-1:0] c_o,
    output logic         found_o
);

    logic [N-1:0] rot;
    int           off;
    int           sum;

    // Rotating a doubled mask right by PE puts channel PE at bit 0, so the
    // lowest set bit of the rotated word is the offset of the next winner.
    always_comb begin
        rot     = N'({mask_i, mask_i} >> pe_i);
        found_o = 1'b0;
        off     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found_o = 1'b1;
                off     = k;
            end
        end
        sum = int'(pe_i) + off;
        if (sum >= N) sum = sum - N;
        c_o = S'(sum);
    end

endmodule

// File: rtl/mux_scan_n1.sv
// rtl/mux_scan_n1.sv - registered N:1 mux with direct and round-robin scan modes, valid/ready output
module mux_scan_n1
    import mux_scan_n1_pkg::*;
#(
    parameter int W = 1,
    parameter int N = 8,
    parameter int S = 3
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [N*W-1:0] d_i,
    input  logic [S-1:0]   a_i,
    input  logic           mode_i,
    input  logic [N-1:0]   mask_i,
    input  logic           rdy_i,
    output logic [W-1:0]   y_o,
    output logic           yv_o,
    output logic [S-1:0]   ya_o
);

    logic [W-1:0] ch [N];
    state_e       state_q, state_d;
    logic [S-1:0] p_q, p_d;
    logic [S-1:0] ya_q, ya_d;
    logic [W-1:0] y_q, y_d;
    logic         yv_q, yv_d;
    logic         ld;
    logic         a_ok;
    logic [S-1:0] pe;
    logic [S-1:0] pick_c;
    logic         pick_found;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign ch[i] = d_i[i*W +: W];
    end

    if (N == (1 << S)) begin : g_a_full
        assign a_ok = 1'b1;
    end else begin : g_a_part
        assign a_ok = (a_i < S'(N));
    end

    assign ld = !yv_q || rdy_i;
    // Still in DIR means this is the first scan load after a switch: start at 0.
    assign pe = (state_q == ST_SCAN) ? p_q : '0;

    mux_scan_n1_rr_pick #(
        .N(N),
        .S(S)
    ) u_pick (
        .mask_i (mask_i),
        .pe_i   (pe),
        .c_o    (pick_c),
        .found_o(pick_found)
    );

    always_comb begin
        state_d = (mode_i == MODE_SCAN) ? ST_SCAN : ST_DIR;
        p_d     = p_q;
        y_d     = y_q;
        yv_d    = yv_q;
        ya_d    = ya_q;
        if (ld) begin
            if (mode_i == MODE_DIR) begin
                yv_d = a_ok;
                if (a_ok) begin
                    y_d  = ch[a_i];
                    ya_d = a_i;
                end
            end else begin
                yv_d = pick_found;
                if (pick_found) begin
                    y_d  = ch[pick_c];
                    ya_d = pick_c;
                    p_d  = (int'(pick_c) == N - 1) ? '0 : pick_c + S'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_DIR;
            p_q     <= '0;
            y_q     <= '0;
            yv_q    <= 1'b0;
            ya_q    <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            y_q     <= y_d;
            yv_q    <= yv_d;
            ya_q    <= ya_d;
        end
    end

    assign y_o  = y_q;
    assign yv_o = yv_q;
    assign ya_o = ya_q;

endmodule

// File: tb/tb_mux_scan_n1.sv
// tb/tb_mux_scan_n1.sv - randomized and directed bench for mux_scan_n1 (N=8 and N=5 instances)
module tb_mux_scan_n1;

    typedef struct {
        logic [3:0] y;
        logic       yv;
        logic [2:0] ya;
        int         p;
        logic       scan_prev;
    } model_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  dch [8];
    logic [31:0] d8_p;
    logic [19:0] d5_p;
    logic [2:0]  a;
    logic        mode;
    logic [7:0]  mask;
    logic        rdy;

    logic [3:0]  y8, y5;
    logic        yv8, yv5;
    logic [2:0]  ya8, ya5;

    int     vectors = 0;
    int     miscompares = 0;
    model_t m8, m5;

    always #5 clk = ~clk;

    always_comb begin
        d8_p = '0;
        for (int i = 0; i < 8; i++) d8_p[i*4 +: 4] = dch[i];
    end
    assign d5_p = d8_p[19:0];

    mux_scan_n1 #(.W(4), .N(8), .S(3)) dut8 (
        .clk_i(clk), .rst_i(rst), .d_i(d8_p), .a_i(a), .mode_i(mode),
        .mask_i(mask), .rdy_i(rdy), .y_o(y8), .yv_o(yv8), .ya_o(ya8)
    );

    mux_scan_n1 #(.W(4), .N(5), .S(3)) dut5 (
        .clk_i(clk), .rst_i(rst), .d_i(d5_p), .a_i(a), .mode_i(mode),
        .mask_i(mask[4:0]), .rdy_i(rdy), .y_o(y5), .yv_o(yv5), .ya_o(ya5)
    );

    // Reference: a sticky output register fed by either a direct pick or a
    // modular search over the enabled channels starting at the scan pointer.
    function automatic model_t model_step(input model_t m, input int n);
        model_t r;
        int     pe;
        int     c;
        r = m;
        if (rst) begin
            r.y = 0; r.yv = 0; r.ya = 0; r.p = 0; r.scan_prev = 0;
            return r;
        end
        if (!m.yv || rdy) begin
            if (!mode) begin
                if (int'(a) < n) begin
                    r.y = dch[a]; r.ya = a; r.yv = 1;
                end else begin
                    r.yv = 0;
                end
            end else begin
                pe = m.scan_prev ? m.p : 0;
                c  = -1;
                for (int off = n - 1; off >= 0; off--)
                    if (mask[(pe + off) % n]) c = (pe + off) % n;
                if (c >= 0) begin
                    r.y = dch[c]; r.ya = 3'(c); r.yv = 1; r.p = (c + 1) % n;
                end else begin
                    r.yv = 0;
                end
            end
        end
        r.scan_prev = mode;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        m8 = model_step(m8, 8);
        m5 = model_step(m5, 5);
        #1;
        check({tag, " y8"}, y8, m8.y);
        check({tag, " yv8"}, yv8, m8.yv);
        check({tag, " ya8"}, ya8, m8.ya);
        check({tag, " y5"}, y5, m5.y);
        check({tag, " yv5"}, yv5, m5.yv);
        check({tag, " ya5"}, ya5, m5.ya);
        check({tag, " p5<5"}, 32'(dut5.p_q < 3'd5), 32'd1);
    endtask

    initial begin
        m8 = '{y: 0, yv: 0, ya: 0, p: 0, scan_prev: 0};
        m5 = m8;
        rst = 1; a = 0; mode = 0; mask = 0; rdy = 0;
        for (int i = 0; i < 8; i++) dch[i] = 4'(i + 8);

        // Reset held with inputs toggling
        step("rst0");
        mode = 1; rdy = 1; mask = 8'hFF; dch[0] = 4'h3;
        step("rst1");
        check("rst y8 zero", y8, 0);
        check("rst yv8 zero", yv8, 0);
        mode = 0; rdy = 0; a = 3'd7; rst = 0; dch[0] = 4'h8;
        step("rst_after");

        // Direct sweep
        rdy = 1;
        for (int i = 0; i < 8; i++) begin
            a = 3'(i);
            step("dir");
            check("dir y8 value", y8, 32'(i + 8));
        end

        // Backpressure holding 0xA
        dch[2] = 4'hA; a = 3'd2;
        step("bp_load");
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            a = 3'($urandom_range(0, 7));
            mode = 1'($urandom_range(0, 1));
            dch[2] = 4'($urandom);
            step("bp_hold");
            check("bp y8 held", y8, 32'hA);
        end
        mode = 0; a = 3'd4; rdy = 1;
        step("bp_release");

        // Scan with sparse mask, then an empty mask
        mode = 1; mask = 8'hA5;
        for (int i = 0; i < 6; i++) step("scan_a5");
        mask = 8'h00;
        step("scan_empty0");
        step("scan_empty1");
        mask = 8'hA5;
        step("scan_resume");

        // All channels enabled: exercises N=5 wrap
        mode = 0; step("dir_gap");
        mode = 1; mask = 8'hFF;
        for (int i = 0; i < 6; i++) step("scan_all");

        // Leave scan mid-sequence and return
        mode = 0; a = 3'd1; step("switch_dir");
        mode = 1; step("switch_scan");
        check("switch ya8 restart", ya8, 0);
        mask = 8'h10; step("single0"); step("single1");

        // Reset during a stall
        rdy = 0; step("stall");
        rst = 1; step("rst_stall");
        check("rst_stall yv8", yv8, 0);
        rst = 0;

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 8; k++) dch[k] = 4'($urandom);
            a    = 3'($urandom);
            mode = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) mask = 8'($urandom) & 8'($urandom);
            rdy  = ($urandom_range(0, 2) != 0);
            rst  = ($urandom_range(0, 60) == 0);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
